fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core; upstream neighbour of the hazard unit.
//  Owns PCF, runs a req/ack handshake to instruction memory and redirects on PCSrcE.
//  Obeys StallF/StallD/FlushD from the hazard unit; presents InstrD/PCD/PCPlus4D to decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PCF value after reset
//  NOP_INSTR 32'h0000_0013  instruction driven on InstrD for a bubble (addi x0,x0,0)
// PORTS
//  clk         in  1   clock, rising edge
//  rst_n       in  1   synchronous reset, active-low
//  StallF      in  1   hold PCF (hazard unit)
//  StallD      in  1   hold IF/ID register (hazard unit)
//  FlushD      in  1   load bubble into IF/ID (hazard unit)
//  PCSrcE      in  1   taken branch/jump resolved in EX
//  PCTargetE   in  32  redirect target
//  imem_req    out 1   fetch request; addr held stable until ack
//  imem_addr   out 32  fetch address
//  imem_ack    in  1   response valid; same-cycle ack allowed
//  imem_rdata  in  32  instruction word, valid with ack
//  InstrD      out 32  IF/ID instruction
//  PCD         out 32  IF/ID PC
//  PCPlus4D    out 32  IF/ID PC+4
//  ValidD      out 1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset: clk and rst_n are the only clock and reset; reset is synchronous and active-low.
//   Values while rst_n=0: PCF=RESET_PC, state=FETCH, imem_req=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
//   Reset mid-request abandons the request; imem shares rst_n.
//  imem_addr: equals PCF in FETCH and equals the in-flight address in DRAIN.
//  imem_req: 1 in FETCH and DRAIN, 0 in HOLD.
//  Accept: a word is accepted when StallF=0, StallD=0 and FlushD=0.
//  Latency: ack in cycle N -> InstrD/ValidD=1 in cycle N+1.
//  IF/ID update, when StallD=0 and FlushD=0:
//   - with an accepted word: load {word, PCF, PCF+4}.
//   - otherwise: load bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged).
//  IF/ID update, other cases:
//   - FlushD=1: load bubble; FlushD wins over StallD.
//   - StallD=1 and FlushD=0: hold contents.
//  FSM FETCH:
//   ack & PCSrcE  -> discard word, PCF<=PCTargetE, stay FETCH
//   ack & accept  -> PCF<=PCF+4, stay FETCH
//   ack & !accept -> capture word into hold_q, go HOLD
//   !ack & PCSrcE -> pend_q<=PCTargetE, go DRAIN (request kept, address frozen)
//   !ack          -> stay
//  FSM HOLD:
//   PCSrcE        -> drop hold_q, PCF<=PCTargetE, go FETCH
//   accept        -> IF/ID<=hold_q, PCF<=PCF+4, go FETCH
//   else          -> stay
//  FSM DRAIN:
//   ack           -> discard word, PCF<=(PCSrcE ? PCTargetE : pend_q), go FETCH
//   !ack & PCSrcE -> pend_q<=PCTargetE (latest redirect wins)
//  Redirects: PCSrcE always beats StallF/StallD for PCF.
//   A redirect never lets a wrong-path word reach IF/ID; the hazard unit flushes D in the same cycle.
//  Arithmetic: PC+4 is 32-bit and wraps modulo 2^32; bits [1:0] of PC are not checked.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   - adds outputs fetch_cnt[31:0] and squash_cnt[31:0], both reset to 0 and wrapping.
//   - fetch_cnt: +1 per word loaded into IF/ID with ValidD=1.
//   - squash_cnt: +1 per discarded imem response or dropped hold_q.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, then ack every cycle, no stalls.
//     -> imem_addr 0,4,8,...; InstrD follows rdata one cycle later; ValidD=1 from cycle 2.
//  2. StallF=StallD=1 for 3 cycles with ack on the first stalled cycle.
//     -> HOLD, imem_req=0, IF/ID frozen.
//     -> on release, the held word appears next cycle and PCF+=4 once.
//  3. Ack latency 3; PCSrcE=1, PCTargetE=0x100 in the second wait cycle.
//     -> addr stays put until ack; that word is discarded; next imem_addr=0x100; no ValidD for the old word.
//  4. PCSrcE=1 with ack in the same cycle.
//     -> next imem_addr=PCTargetE and the word never appears.
//     -> Also FlushD=1 with StallD=1 -> ValidD=0.
//  5. rst_n=0 while in DRAIN.
//     -> next cycle state FETCH, PCF=RESET_PC, ValidD=0; imem_req rises only after rst_n=1.
//  6. FETCH_PERF_EN: run scenarios 1 and 3.
//     -> fetch_cnt equals the number of ValidD=1 loads; squash_cnt=1 for scenario 3.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake bundle between fetch_stage and imem.
//   imem_req   : fetch request, address held stable until acknowledged
//   imem_addr  : fetch address
//   imem_ack   : response valid (may arrive in the same cycle as the request)
//   imem_rdata : instruction word, valid together with imem_ack
// master = fetch side, slave = memory side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register of a 5-stage RV32I core.
// Owns PCF, runs the req/ack handshake to instruction memory, redirects on
// PCSrcE and obeys StallF/StallD/FlushD from the hazard unit.
//
// Ports
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   StallF, StallD      : hold PCF / hold IF/ID register
//   FlushD              : load a bubble into IF/ID (wins over StallD)
//   PCSrcE, PCTargetE   : taken branch/jump resolved in EX and its target
//   imem                : fetch_stage_if.master instruction-memory handshake
//   InstrD, PCD,
//   PCPlus4D, ValidD    : IF/ID register contents presented to decode
//   fetch_cnt,
//   squash_cnt          : performance counters (only with FETCH_PERF_EN)
//
// Configuration macro: FETCH_PERF_EN adds the fetch_cnt/squash_cnt outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                PCSrcE,
  input  logic [31:0]         PCTargetE,
  fetch_stage_if.master       imem,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCD,
  output logic [31:0]         PCPlus4D,
  output logic                ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         squash_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pcf_p0, pcf_nxt;
  logic [31:0] pend_q, pend_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [31:0] pcf_plus4;
  logic        accept;
  logic        load_word;
  logic        squash;
  logic [31:0] word_sel;

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  assign accept    = !StallF && !StallD && !FlushD;
  assign pcf_plus4 = pcf_p0 + 32'd4;

  // PCF never moves while a request is outstanding, so it is also the
  // in-flight address in DRAIN. The request is masked during reset so it
  // only rises once rst_n is released.
  assign imem.imem_addr = pcf_p0;
  assign imem.imem_req  = rst_n && (state != HOLD);

  // ---- IF: fetch FSM next-state logic ----
  always_comb begin
    state_nxt = state;
    pcf_nxt   = pcf_p0;
    pend_nxt  = pend_q;
    hold_nxt  = hold_q;
    load_word = 1'b0;
    squash    = 1'b0;
    word_sel  = imem.imem_rdata;
    case (state)
      FETCH: begin
        if (imem.imem_ack) begin
          if (PCSrcE) begin
            // Wrong-path word: drop it and restart at the target.
            pcf_nxt = PCTargetE;
            squash  = 1'b1;
          end else if (accept) begin
            pcf_nxt   = pcf_plus4;
            load_word = 1'b1;
          end else begin
            // Decode cannot take it yet; park the word and stop requesting.
            hold_nxt  = imem.imem_rdata;
            state_nxt = HOLD;
          end
        end else if (PCSrcE) begin
          // Request must stay up with a frozen address until the memory
          // answers; remember where to go afterwards.
          pend_nxt  = PCTargetE;
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_nxt   = PCTargetE;
          squash    = 1'b1;
          state_nxt = FETCH;
        end else if (accept) begin
          pcf_nxt   = pcf_plus4;
          load_word = 1'b1;
          word_sel  = hold_q;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (imem.imem_ack) begin
          pcf_nxt   = PCSrcE ? PCTargetE : pend_q;
          squash    = 1'b1;
          state_nxt = FETCH;
        end else if (PCSrcE) begin
          pend_nxt = PCTargetE;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FETCH;
      pcf_p0 <= RESET_PC;
    end else begin
      state  <= state_nxt;
      pcf_p0 <= pcf_nxt;
    end
  end

  // Parking registers carry data only; their contents are meaningless
  // outside DRAIN/HOLD, so they are not reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_nxt;
    hold_q <= hold_nxt;
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'd0;
      pc4_p1   <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (FlushD) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (!StallD) begin
      if (load_word) begin
        instr_p1 <= word_sel;
        pc_p1    <= pcf_p0;
        pc4_p1   <= pcf_plus4;
        vld_p1   <= 1'b1;
      end else begin
        // Bubble keeps the last PC pair so decode-side PC consumers stay stable.
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign InstrD   = instr_p1;
  assign PCD      = pc_p1;
  assign PCPlus4D = pc4_p1;
  assign ValidD   = vld_p1;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt  <= 32'd0;
      squash_cnt <= 32'd0;
    end else begin
      // A word is counted only if it actually lands in IF/ID.
      if (load_word && !StallD && !FlushD) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (squash) begin
        squash_cnt <= squash_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
